mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single external memory interface (ext_mem_* bus: 32-bit address, 256-bit line data, cs/we/ack handshake) between the instruction-side and data-side L1 caches. It sits between the caches' memory-side ports and the CPU's ext_mem_* pins. Each cache sees a private, unchanged memory port.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 256, cache-line data width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_addr_i  in  ADDR_W  instruction-cache request address.
- p0_cs_i  in  1  instruction-cache request.
- p0_we_i  in  1  instruction-cache write (1) / read (0).
- p0_data_i  in  DATA_W  instruction-cache write line.
- p0_data_o  out  DATA_W  read line returned to port 0.
- p0_ack_o  out  1  one-cycle completion pulse to port 0.
- p1_addr_i, p1_cs_i, p1_we_i, p1_data_i, p1_data_o, p1_ack_o: same as above for the data cache (port 1).
- mem_addr_o  out  ADDR_W  to ext_mem_addr.
- mem_cs_o  out  1  to ext_mem_cs.
- mem_we_o  out  1  to ext_mem_we.
- mem_data_o  out  DATA_W  to ext_mem_data_o.
- mem_data_i  in  DATA_W  from ext_mem_data_i.
- mem_ack_i  in  1  from ext_mem_ack; one-cycle pulse.
- grant_o  out  1  index of the port owning the current or last transaction.
- busy_o  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: samples p0_cs_i and p1_cs_i.
  - No request: stay in IDLE.
  - Otherwise: choose the winner, latch its addr/we/data into the output registers, set grant_o, go to BUSY.
- BUSY:
  - mem_cs_o=1; mem_addr_o, mem_we_o and mem_data_o come from the latched registers, stable for the whole transaction.
  - Requester input changes are ignored.
  - On mem_ack_i: register mem_data_i into the winner's data_o (reads only; writes leave data_o unchanged), drop mem_cs_o, go to RESP.
- RESP:
  - Winner's ack_o=1 for exactly this cycle; loser's ack_o stays 0.
  - Next state is IDLE unconditionally.
  - mem_cs_o is 0 in RESP and IDLE, so it is low for at least 2 cycles between transactions.
- Requester rule: a port holds cs/addr/we/data stable until it sees ack_o, then drops cs at the following edge. A cs still high when the arbiter returns to IDLE is treated as a new request.
- Default arbitration (fixed priority): port 1 (data cache) wins when both ports request, because MEM-stage stalls freeze the whole pipeline.
- mem_ack_i outside BUSY is ignored.
- p*_data_o holds its last returned line until overwritten.

## Timing
- Reset (rst=0, asynchronous): state=IDLE; mem_cs_o, mem_we_o, p0_ack_o, p1_ack_o, busy_o, grant_o = 0; mem_addr_o, mem_data_o, p0_data_o, p1_data_o = 0; round-robin pointer = port 0.
- Reset mid-transaction: the transaction is abandoned with no ack issued; mem_cs_o falls immediately (asynchronously).
- Latency, cycle by cycle:
  - Request seen at edge N → mem_cs_o high from N+1.
  - mem_ack_i sampled at edge M → ack_o high in cycle M+1 and data_o valid from M+1.
  - Arbiter back in IDLE at M+2.
  - Minimum request-to-ack is 2 cycles plus the memory latency.
- Simultaneous requests at edge N: exactly one is granted; the other is served in the next IDLE cycle if its cs is still high.
- grant_o and busy_o are registered; no output is combinational from any input.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port; on a tie the preferred port wins.
  - On every grant the pointer moves to the other port.
  - A lone requester always wins regardless of the pointer.
- MEM_ARB_RR_EN undefined: fixed priority, port 1 over port 0. No pointer register is built.

## Test plan
- Single read: p0 requests 0x0000_0040 read; memory acks after 10 cycles with line 0xA5…A5 → mem_cs_o high for 10 cycles, mem_addr_o=0x40, mem_we_o=0; p0_ack_o pulses once; p0_data_o=0xA5…A5; p1_ack_o stays 0.
- Single write: p1 writes 0x0000_0200 with pattern 0x1234… → mem_we_o=1, mem_data_o equals the pattern for the whole of BUSY; p1_ack_o pulses once; p1_data_o unchanged.
- Contention, fixed priority (macro off): both ports request at the same edge → p1 served first, then p0; the two mem_cs_o windows are separated by 2 low cycles.
- Contention, round-robin (macro on): both ports hold cs through 4 back-to-back transactions → grant order p0, p1, p0, p1.
- Reset mid-BUSY: assert rst=0 after 3 cycles of mem_cs_o → mem_cs_o falls without waiting for an edge; no ack on either port; after release the arbiter is IDLE, and a stray mem_ack_i is ignored.
- Input churn: p0 changes p0_addr_i during BUSY → mem_addr_o keeps the originally latched address until RESP.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two L1 caches, the arbiter and the external memory pins.
// The arbiter connects through 'slave'; caches and memory together form the 'master' side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic [ADDR_W-1:0] p0_addr_i;
    logic              p0_cs_i;
    logic              p0_we_i;
    logic [DATA_W-1:0] p0_data_i;
    logic [DATA_W-1:0] p0_data_o;
    logic              p0_ack_o;

    logic [ADDR_W-1:0] p1_addr_i;
    logic              p1_cs_i;
    logic              p1_we_i;
    logic [DATA_W-1:0] p1_data_i;
    logic [DATA_W-1:0] p1_data_o;
    logic              p1_ack_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_cs_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    logic              grant_o;
    logic              busy_o;

    modport slave (
        input  p0_addr_i, p0_cs_i, p0_we_i, p0_data_i,
        output p0_data_o, p0_ack_o,
        input  p1_addr_i, p1_cs_i, p1_we_i, p1_data_i,
        output p1_data_o, p1_ack_o,
        output mem_addr_o, mem_cs_o, mem_we_o, mem_data_o,
        input  mem_data_i, mem_ack_i,
        output grant_o, busy_o
    );

    modport master (
        output p0_addr_i, p0_cs_i, p0_we_i, p0_data_i,
        input  p0_data_o, p0_ack_o,
        output p1_addr_i, p1_cs_i, p1_we_i, p1_data_i,
        input  p1_data_o, p1_ack_o,
        input  mem_addr_o, mem_cs_o, mem_we_o, mem_data_o,
        output mem_data_i, mem_ack_i,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the external line-memory port between I-cache (p0) and D-cache (p1).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic              win;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_we;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;

    // Pointer only breaks ties; a lone requester wins regardless.
    always_comb begin
        win = bus.p1_cs_i;
        if (bus.p0_cs_i && bus.p1_cs_i)
            win = rr_ptr;
    end
`else
    // D-cache first: a MEM-stage stall freezes the whole pipeline.
    always_comb begin
        win = bus.p1_cs_i;
    end
`endif

    always_comb begin
        sel_addr = win ? bus.p1_addr_i : bus.p0_addr_i;
        sel_data = win ? bus.p1_data_i : bus.p0_data_i;
        sel_we   = win ? bus.p1_we_i   : bus.p0_we_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            bus.mem_addr_o <= '0;
            bus.mem_data_o <= '0;
            bus.mem_cs_o   <= 1'b0;
            bus.mem_we_o   <= 1'b0;
            bus.p0_data_o  <= '0;
            bus.p1_data_o  <= '0;
            bus.p0_ack_o   <= 1'b0;
            bus.p1_ack_o   <= 1'b0;
            bus.grant_o    <= 1'b0;
            bus.busy_o     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            rr_ptr         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.p0_cs_i || bus.p1_cs_i) begin
                        bus.mem_addr_o <= sel_addr;
                        bus.mem_data_o <= sel_data;
                        bus.mem_we_o   <= sel_we;
                        bus.mem_cs_o   <= 1'b1;
                        bus.grant_o    <= win;
                        bus.busy_o     <= 1'b1;
                        state          <= BUSY;
`ifdef MEM_ARB_RR_EN
                        rr_ptr         <= ~rr_ptr;
`endif
                    end
                end
                BUSY: begin
                    // Latched request stays on the bus; requester inputs are ignored here.
                    if (bus.mem_ack_i) begin
                        if (!bus.mem_we_o) begin
                            if (bus.grant_o) bus.p1_data_o <= bus.mem_data_i;
                            else             bus.p0_data_o <= bus.mem_data_i;
                        end
                        if (bus.grant_o) bus.p1_ack_o <= 1'b1;
                        else             bus.p0_ack_o <= 1'b1;
                        bus.mem_cs_o <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    bus.p0_ack_o <= 1'b0;
                    bus.p1_ack_o <= 1'b0;
                    bus.busy_o   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard of expected memory transactions is filled as
// requests are driven and drained as each mem_cs_o window opens; a small memory model acks.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 256;
    typedef logic [DW-1:0] line_t;
    typedef struct {
        bit            port;
        logic [AW-1:0] addr;
        bit            we;
        line_t         wdata;
        line_t         rline;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic  m_ack, stray_ack;
    line_t m_data;
    assign bus.mem_ack_i  = m_ack | stray_ack;
    assign bus.mem_data_i = m_data;

    int    vectors, miscompares;
    txn_t  sb[$];
    txn_t  cur;
    bit    order[$];
    bit    active, prev_cs, have_prev, hold;
    int    mcnt, lat, cs_len, low_run, last_gap;
    int    ack_cnt[2];
    line_t exp_pd[2];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, requester ack handling and memory model, all evaluated at the falling edge.
    task automatic monitor();
        logic cs, a0, a1, rose, fell;
        if (!rst) begin
            prev_cs = 1'b0; active = 1'b0; mcnt = 0; m_ack = 1'b0;
        end else begin
            cs = bus.mem_cs_o; a0 = bus.p0_ack_o; a1 = bus.p1_ack_o;
            rose = cs && !prev_cs;
            fell = !cs && prev_cs;
            chk("busy", bus.busy_o, cs | fell);
            if (rose) begin
                if (have_prev) chk("gap_min", low_run >= 2, 1);
                last_gap = low_run;
                cs_len = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_txn", cs, 0);
                    active = 1'b0;
                end else begin
                    cur = sb.pop_front();
                    active = 1'b1;
                end
            end
            if (cs) begin
                low_run = 0;
                cs_len++;
                if (active) begin
                    chk("mem_addr", bus.mem_addr_o, cur.addr);
                    chk("mem_we", bus.mem_we_o, cur.we);
                    chk("mem_data", bus.mem_data_o, cur.wdata);
                    chk("grant", bus.grant_o, cur.port);
                end
            end else begin
                low_run++;
            end
            if (fell && active) begin
                if (!cur.we) exp_pd[cur.port] = cur.rline;
                chk("cs_len", cs_len, lat);
                chk("win_ack", cur.port ? a1 : a0, 1);
                chk("lose_ack", cur.port ? a0 : a1, 0);
                chk("p0_data", bus.p0_data_o, exp_pd[0]);
                chk("p1_data", bus.p1_data_o, exp_pd[1]);
                ack_cnt[cur.port]++;
                order.push_back(cur.port);
                active = 1'b0;
                have_prev = 1'b1;
                if (!hold) begin
                    if (cur.port) bus.p1_cs_i = 1'b0;
                    else          bus.p0_cs_i = 1'b0;
                end
            end else if (a0 | a1) begin
                chk("spurious_ack", {a0, a1}, 2'b00);
            end
            if (cs) mcnt++;
            else    mcnt = 0;
            m_ack  = cs && (mcnt == lat);
            m_data = (active && !cur.we) ? cur.rline : '1;
            prev_cs = cs;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic wait_acks(input int n, input int budget);
        int base;
        int k;
        base = ack_cnt[0] + ack_cnt[1];
        k = 0;
        while ((ack_cnt[0] + ack_cnt[1] - base) < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("ack_timeout", (ack_cnt[0] + ack_cnt[1] - base) >= n, 1);
    endtask

    task automatic drive(input bit port, input logic [AW-1:0] addr, input bit we, input line_t data);
        if (port) begin
            bus.p1_addr_i = addr; bus.p1_we_i = we; bus.p1_data_i = data; bus.p1_cs_i = 1'b1;
        end else begin
            bus.p0_addr_i = addr; bus.p0_we_i = we; bus.p0_data_i = data; bus.p0_cs_i = 1'b1;
        end
    endtask

    task automatic push_exp(input bit port, input logic [AW-1:0] addr, input bit we,
                            input line_t wdata, input line_t rline);
        txn_t t;
        t.port = port; t.addr = addr; t.we = we; t.wdata = wdata; t.rline = rline;
        sb.push_back(t);
    endtask

    task automatic apply_reset();
        bus.p0_cs_i = 1'b0; bus.p1_cs_i = 1'b0;
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        sb.delete(); order.delete();
        exp_pd[0] = '0; exp_pd[1] = '0;
        have_prev = 1'b0; low_run = 0;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        line_t a5, pat;
        int base;
        vectors = 0; miscompares = 0;
        rst = 1'b0; hold = 1'b0; lat = 4; stray_ack = 1'b0; m_ack = 1'b0; m_data = '0;
        active = 1'b0; prev_cs = 1'b0; have_prev = 1'b0; mcnt = 0; cs_len = 0;
        low_run = 0; last_gap = 0; ack_cnt[0] = 0; ack_cnt[1] = 0;
        exp_pd[0] = '0; exp_pd[1] = '0;
        bus.p0_addr_i = '0; bus.p0_cs_i = 1'b0; bus.p0_we_i = 1'b0; bus.p0_data_i = '0;
        bus.p1_addr_i = '0; bus.p1_cs_i = 1'b0; bus.p1_we_i = 1'b0; bus.p1_data_i = '0;
        a5  = {32{8'hA5}};
        pat = {8{32'h1234_5678}};

        // Reset state
        #2;
        chk("rst_cs", bus.mem_cs_o, 0);
        chk("rst_we", bus.mem_we_o, 0);
        chk("rst_p0_ack", bus.p0_ack_o, 0);
        chk("rst_p1_ack", bus.p1_ack_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_addr", bus.mem_addr_o, 0);
        chk("rst_mdata", bus.mem_data_o, 0);
        chk("rst_p0_data", bus.p0_data_o, 0);
        chk("rst_p1_data", bus.p1_data_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick(2);

        // Single read on port 0, 10-cycle memory
        lat = 10;
        push_exp(0, 32'h0000_0040, 0, '0, a5);
        drive(0, 32'h0000_0040, 0, '0);
        wait_acks(1, 40);
        chk("read_p1_ack_cnt", ack_cnt[1], 0);
        tick(2);

        // Single write on port 1: p1_data_o must not pick up the memory bus
        lat = 5;
        push_exp(1, 32'h0000_0200, 1, pat, '0);
        drive(1, 32'h0000_0200, 1, pat);
        wait_acks(1, 30);
        tick(2);
        chk("write_p1_data", bus.p1_data_o, 0);

        // Input churn: requester address changes mid-transaction
        lat = 8;
        push_exp(0, 32'h0000_0100, 0, '0, {8{32'hC0DE_0001}});
        drive(0, 32'h0000_0100, 0, '0);
        tick(3);
        bus.p0_addr_i = 32'h0000_0999;
        wait_acks(1, 30);
        tick(2);

        // Simultaneous one-shot requests
        apply_reset();
        lat = 3;
`ifdef MEM_ARB_RR_EN
        push_exp(0, 32'h0000_1000, 0, '0, {8{32'hD0D0_0000}});
        push_exp(1, 32'h0000_2000, 0, '0, {8{32'hE1E1_0000}});
`else
        push_exp(1, 32'h0000_2000, 0, '0, {8{32'hE1E1_0000}});
        push_exp(0, 32'h0000_1000, 0, '0, {8{32'hD0D0_0000}});
`endif
        drive(0, 32'h0000_1000, 0, '0);
        drive(1, 32'h0000_2000, 0, '0);
        wait_acks(2, 40);
`ifdef MEM_ARB_RR_EN
        chk("contend_first", order.size() > 0 ? order[0] : 1'bx, 0);
        chk("contend_second", order.size() > 1 ? order[1] : 1'bx, 1);
`else
        chk("contend_first", order.size() > 0 ? order[0] : 1'bx, 1);
        chk("contend_second", order.size() > 1 ? order[1] : 1'bx, 0);
`endif
        chk("contend_gap", last_gap, 2);
        tick(2);

        // Both ports hold cs through four back-to-back transactions
        apply_reset();
        lat = 3;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            if (i % 2 == 0) push_exp(0, 32'h0000_0300, 0, '0, {8{32'h1000 + i}});
            else            push_exp(1, 32'h0000_0400, 0, '0, {8{32'h1000 + i}});
`else
            push_exp(1, 32'h0000_0400, 0, '0, {8{32'h1000 + i}});
`endif
        end
        hold = 1'b1;
        drive(0, 32'h0000_0300, 0, '0);
        drive(1, 32'h0000_0400, 0, '0);
        wait_acks(4, 60);
        hold = 1'b0;
        bus.p0_cs_i = 1'b0;
        bus.p1_cs_i = 1'b0;
        tick(3);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            chk("hold_order", order.size() > i ? order[i] : 1'bx, (i % 2 == 0) ? 0 : 1);
`else
            chk("hold_order", order.size() > i ? order[i] : 1'bx, 1);
`endif
        end

        // Reset in the middle of BUSY: cs drops asynchronously, no ack, stray ack ignored
        lat = 20;
        push_exp(0, 32'h0000_0080, 0, '0, {8{32'hBAD0_BAD0}});
        drive(0, 32'h0000_0080, 0, '0);
        tick(3);
        chk("pre_rst_cs", bus.mem_cs_o, 1);
        base = ack_cnt[0] + ack_cnt[1];
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_cs", bus.mem_cs_o, 0);
        chk("async_rst_busy", bus.busy_o, 0);
        chk("async_rst_p0_ack", bus.p0_ack_o, 0);
        bus.p0_cs_i = 1'b0;
        sb.delete();
        exp_pd[0] = '0; exp_pd[1] = '0;
        have_prev = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        stray_ack = 1'b1;
        tick(1);
        stray_ack = 1'b0;
        tick(3);
        chk("stray_cs", bus.mem_cs_o, 0);
        chk("stray_busy", bus.busy_o, 0);
        chk("stray_p0_data", bus.p0_data_o, 0);
        chk("rst_no_ack", ack_cnt[0] + ack_cnt[1], base);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
